// File: rtl/sig_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sig_pkg
// Purpose  : Shared definitions for the highway/country-road signal
//            controller: light colour codes, the FSM state encoding and a
//            helper that sizes the dwell-time counter.
// Revision : 1.0  initial release
// ============================================================================
package sig_pkg;

    // Light colour encoding seen by the signal-head encoders (3 is unused).
    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    // Controller states.
    typedef enum logic [2:0] {
        S0 = 3'd0,   // highway green
        S1 = 3'd1,   // highway yellow
        S2 = 3'd2,   // all red
        S3 = 3'd3,   // country green
        S4 = 3'd4    // country yellow
    } state_t;

    // Counter width: clog2 of the longest dwell, but never below one bit.
    // The counter only has to reach DELAY-1, so clog2(DELAY) bits suffice.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage : sig_pkg
`default_nettype wire

// File: rtl/sig_delay_counter.sv
`default_nettype none
// ============================================================================
// Module   : sig_delay_counter
// Purpose  : Dwell-time counter for the timed controller states. Restarts at
//            zero whenever the state changes and flags the final cycle.
// Ports    : clock   - system clock (rising edge)
//            clear   - synchronous active-high reset
//            restart - state is changing at this edge; counter reloads 0
//            enable  - current state is a timed state; count advances
//            last    - terminal count (dwell length minus one)
//            done    - high during the last cycle of the dwell
// Revision : 1.0  initial release
// ============================================================================
module sig_delay_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             restart,
    input  logic             enable,
    input  logic [WIDTH-1:0] last,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (clear || restart) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // The terminal value is compared rather than a limit so that the limit
    // itself never needs an extra bit when it is a power of two.
    assign done = enable && (r_count == last);

endmodule : sig_delay_counter
`default_nettype wire

// File: rtl/sig_control.sv
`default_nettype none
// ============================================================================
// Module   : sig_control
// Purpose  : Moore-type traffic-signal controller. Highway rests on green;
//            a country-road car (X) triggers highway yellow, all red, and
//            country green held while X stays high, then country yellow and
//            back to highway green.
// Ports    : clock - system clock, all state updates on its rising edge
//            clear - synchronous active-high reset to highway green
//            X     - country-road car sensor, 1 = car present
//            hwy   - highway light colour   (0=RED 1=YELLOW 2=GREEN)
//            cntry - country light colour   (same encoding)
// Revision : 1.0  initial release
// ============================================================================
module sig_control
    import sig_pkg::*;
#(
    parameter int Y2RDELAY = 3,   // cycles in each yellow state
    parameter int R2GDELAY = 2    // cycles in the all-red state
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       X,
    output logic [1:0] hwy,
    output logic [1:0] cntry
);

    localparam int CNT_W = cnt_width(Y2RDELAY, R2GDELAY);

    // Dwell lengths below one cycle cannot be represented.
    generate
        if (Y2RDELAY < 1) begin : g_bad_y2r
            $error("sig_control: Y2RDELAY must be >= 1");
        end
        if (R2GDELAY < 1) begin : g_bad_r2g
            $error("sig_control: R2GDELAY must be >= 1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(Y2RDELAY - 1);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(R2GDELAY - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_timed;
    logic [CNT_W-1:0] w_last;
    logic             w_done;
    logic             w_restart;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Dwell selection depends only on the current state, kept apart from
    // the next-state logic so the done flag has no path through it.
    // ------------------------------------------------------------------
    always_comb begin
        w_timed = 1'b0;
        w_last  = '0;
        case (r_state)
            S1, S4: begin
                w_timed = 1'b1;
                w_last  = Y_LAST;
            end
            S2: begin
                w_timed = 1'b1;
                w_last  = R_LAST;
            end
            default: begin
                w_timed = 1'b0;
                w_last  = '0;
            end
        endcase
    end

    // Counter reloads on every state change so each entry starts at zero.
    assign w_restart = (w_state_next != r_state);

    sig_delay_counter #(
        .WIDTH (CNT_W)
    ) u_delay (
        .clock   (clock),
        .clear   (clear),
        .restart (w_restart),
        .enable  (w_timed),
        .last    (w_last),
        .done    (w_done)
    );

    // ------------------------------------------------------------------
    // Next-state logic. X is only looked at in the two untimed states,
    // so a request during a timed phase never shortens or restarts it.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S0:      if (X)      w_state_next = S1;
            S1:      if (w_done) w_state_next = S2;
            S2:      if (w_done) w_state_next = S3;
            S3:      if (!X)     w_state_next = S4;
            S4:      if (w_done) w_state_next = S0;
            default:             w_state_next = S0;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode straight from the state register (no path from X).
    // ------------------------------------------------------------------
    always_comb begin
        hwy   = RED;
        cntry = RED;
        case (r_state)
            S0: begin hwy = GREEN;  cntry = RED;    end
            S1: begin hwy = YELLOW; cntry = RED;    end
            S2: begin hwy = RED;    cntry = RED;    end
            S3: begin hwy = RED;    cntry = GREEN;  end
            S4: begin hwy = RED;    cntry = YELLOW; end
            default: begin hwy = RED; cntry = RED;  end
        endcase
    end

endmodule : sig_control
`default_nettype wire

// File: tb/tb_sig_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_sig_control
// Purpose  : Directed self-checking bench for sig_control. One instance with
//            default delays (3/2) and one with Y2RDELAY=1, R2GDELAY=4.
// Revision : 1.0  initial release
// ============================================================================
module tb_sig_control;

    logic       clock;
    logic       clear;
    logic       x;
    logic       x2;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic [1:0] hwy2;
    logic [1:0] cntry2;

    int checks   = 0;
    int failures = 0;

    sig_control #(
        .Y2RDELAY (3),
        .R2GDELAY (2)
    ) dut (
        .clock (clock),
        .clear (clear),
        .X     (x),
        .hwy   (hwy),
        .cntry (cntry)
    );

    sig_control #(
        .Y2RDELAY (1),
        .R2GDELAY (4)
    ) dut2 (
        .clock (clock),
        .clear (clear),
        .X     (x2),
        .hwy   (hwy2),
        .cntry (cntry2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs_h,
                         input logic [1:0] obs_c, input logic [1:0] exp_h,
                         input logic [1:0] exp_c);
        checks++;
        assert ({obs_h, obs_c} === {exp_h, exp_c})
        else begin
            failures++;
            $error("FAIL %s: hwy/cntry observed %0d/%0d expected %0d/%0d",
                   tag, obs_h, obs_c, exp_h, exp_c);
        end
    endtask

    // Expected lights after edges n..n+9 for a one-cycle request (3/2).
    logic [1:0] req_h [10];
    logic [1:0] req_c [10];

    // Expected lights after edges p..p+7 for a one-cycle request (1/4).
    logic [1:0] sw_h [8];
    logic [1:0] sw_c [8];

    initial begin
        req_h = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 2};
        req_c = '{0, 0, 0, 0, 0, 2, 1, 1, 1, 0};
        sw_h  = '{1, 0, 0, 0, 0, 0, 0, 2};
        sw_c  = '{0, 0, 0, 0, 0, 2, 1, 0};

        clear = 1'b1;
        x     = 1'b0;
        x2    = 1'b0;

        // Reset: two edges with clear high.
        step(); check("reset_e1", hwy, cntry, 2'd2, 2'd0);
        step(); check("reset_e2", hwy, cntry, 2'd2, 2'd0);
        check("reset_dut2", hwy2, cntry2, 2'd2, 2'd0);
        clear = 1'b0;

        // Idle: highway stays green with no car.
        for (int i = 0; i < 42; i++) begin
            step(); check("idle_hold", hwy, cntry, 2'd2, 2'd0);
        end

        // Full request: single-cycle pulse, already low on country green.
        x = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            x = 1'b0;
            check($sformatf("req_n+%0d", i), hwy, cntry, req_h[i], req_c[i]);
        end
        step(); check("after_req_idle", hwy, cntry, 2'd2, 2'd0);

        // Held request: X high for 20 edges.
        x = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i < 3)      check("held_hy", hwy, cntry, 2'd1, 2'd0);
            else if (i < 5) check("held_rr", hwy, cntry, 2'd0, 2'd0);
            else            check("held_cg", hwy, cntry, 2'd0, 2'd2);
        end
        x = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); check("held_cy", hwy, cntry, 2'd0, 2'd1);
        end
        step(); check("held_back", hwy, cntry, 2'd2, 2'd0);
        step(); check("held_idle", hwy, cntry, 2'd2, 2'd0);

        // Reset while in all-red, with a new X pulse during the sequence.
        x = 1'b1;
        step(); check("mid_hy0", hwy, cntry, 2'd1, 2'd0);
        x = 1'b0;
        step(); check("mid_hy1", hwy, cntry, 2'd1, 2'd0);
        x = 1'b1;
        step(); check("mid_hy2_x_ignored", hwy, cntry, 2'd1, 2'd0);
        x = 1'b0;
        step(); check("mid_rr0", hwy, cntry, 2'd0, 2'd0);
        clear = 1'b1;
        step(); check("mid_clear", hwy, cntry, 2'd2, 2'd0);
        clear = 1'b0;
        step(); check("mid_idle1", hwy, cntry, 2'd2, 2'd0);
        step(); check("mid_idle2", hwy, cntry, 2'd2, 2'd0);

        // Clean restart after the mid-sequence reset.
        x = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            x = 1'b0;
            check($sformatf("rereq_n+%0d", i), hwy, cntry, req_h[i], req_c[i]);
        end

        // Back-to-back: X high through country yellow.
        x = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("b2b_first_n+%0d", i), hwy, cntry,
                  (i == 5) ? 2'd0 : req_h[i], (i == 5) ? 2'd2 : req_c[i]);
        end
        x = 1'b0;
        step(); check("b2b_cy0", hwy, cntry, 2'd0, 2'd1);
        x = 1'b1;
        step(); check("b2b_cy1", hwy, cntry, 2'd0, 2'd1);
        step(); check("b2b_cy2", hwy, cntry, 2'd0, 2'd1);
        step(); check("b2b_s0_one_cycle", hwy, cntry, 2'd2, 2'd0);
        step(); check("b2b_s1_again", hwy, cntry, 2'd1, 2'd0);
        x = 1'b0;
        for (int i = 1; i < 10; i++) begin
            step();
            check($sformatf("b2b_second_n+%0d", i), hwy, cntry, req_h[i], req_c[i]);
        end

        // Parameter sweep instance: 1-cycle yellows, 4-cycle all red.
        check("sweep_idle", hwy2, cntry2, 2'd2, 2'd0);
        x2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            x2 = 1'b0;
            check($sformatf("sweep_p+%0d", i), hwy2, cntry2, sw_h[i], sw_c[i]);
        end
        step(); check("sweep_idle_after", hwy2, cntry2, 2'd2, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sig_control
`default_nettype wire
